// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with MEM priority, bounded IF starvation and fetch cancellation on flush.
module mem_port_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [1:0]    dm_wbits,
    input  logic [2:0]    dm_rbits,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_ack,
    output logic [31:0]   dm_rdata,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_wbits,
    output logic [2:0]    mem_rbits,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(LATENCY);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    // Fetches always read a full word.
    localparam logic [2:0] IF_RBITS = 3'b010;

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            cancel_q, cancel_d;
    logic            we_q, we_d;
    logic [1:0]      wbits_q, wbits_d;
    logic [2:0]      rbits_q, rbits_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            done;
    logic            if_elig;

    assign if_elig = if_req & ~if_flush;
    assign done    = (state_q != IDLE) && (cnt_q == CNT_LAST);

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        cancel_d = cancel_q;
        we_d     = we_q;
        wbits_d  = wbits_q;
        rbits_d  = rbits_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (dm_req && ((starve_q < STARVE_LIM) || !if_elig)) begin
                    state_d = ACC_D;
                    cnt_d   = CW'(1);
                    we_d    = dm_we;
                    wbits_d = dm_wbits;
                    rbits_d = dm_rbits;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    if (if_elig) starve_d = starve_q + SW'(1);
                end else if (if_elig) begin
                    state_d  = ACC_I;
                    cnt_d    = CW'(1);
                    we_d     = 1'b0;
                    wbits_d  = 2'b00;
                    rbits_d  = IF_RBITS;
                    addr_d   = if_addr;
                    wdata_d  = 32'h0;
                    starve_d = '0;
                end
            end
            ACC_I, ACC_D: begin
                // The memory cannot abort, so a flush only hides the fetch result.
                if (state_q == ACC_I && if_flush) cancel_d = 1'b1;
                if (done) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    cancel_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the latched access
    // fields are reset too because they drive memory-facing outputs directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            cancel_q <= 1'b0;
            we_q     <= 1'b0;
            wbits_q  <= 2'b00;
            rbits_q  <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            cancel_q <= cancel_d;
            we_q     <= we_d;
            wbits_q  <= wbits_d;
            rbits_q  <= rbits_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_en    = (state_q != IDLE);
    assign mem_we    = (state_q == ACC_D) && done && we_q;
    assign mem_wbits = wbits_q;
    assign mem_rbits = rbits_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign dm_ack   = (state_q == ACC_D) && done;
    assign if_ack   = (state_q == ACC_I) && done && !cancel_q && !if_flush;
    assign dm_rdata = dm_ack ? mem_rdata : 32'h0;
    assign if_rdata = if_ack ? mem_rdata : 32'h0;
    assign dm_stall = dm_req & ~dm_ack;
    assign if_stall = if_req & ~if_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model that
// tracks grant time, owner and starvation count per access.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 3;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          if_stall;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [1:0]    dm_wbits = 2'b00;
    logic [2:0]    dm_rbits = 3'b000;
    logic [AW-1:0] dm_addr = '0;
    logic [31:0]   dm_wdata = 32'h0;
    logic          dm_ack;
    logic [31:0]   dm_rdata;
    logic          dm_stall;
    logic          mem_en;
    logic          mem_we;
    logic [1:0]    mem_wbits;
    logic [2:0]    mem_rbits;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    mem_port_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wbits(dm_wbits), .dm_rbits(dm_rbits),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wbits(mem_wbits), .mem_rbits(mem_rbits),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference state.
    int          cyc;
    bit          m_busy, m_owner_dm, m_cancel;
    int          m_grant;
    int          m_starve;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [1:0]  m_wbits;
    logic [2:0]  m_rbits;
    int          m_stores, obs_stores;
    bit          prev_if_ack, prev_dm_ack, last_e_we;

    task automatic model_reset();
        cyc = 0; m_busy = 0; m_owner_dm = 0; m_cancel = 0; m_grant = 0; m_starve = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; m_wbits = 0; m_rbits = 0;
        prev_if_ack = 0; prev_dm_ack = 0; last_e_we = 0;
    endtask

    task automatic drive(input int if_pct, input int dm_pct);
        if (!if_req || prev_if_ack) begin
            if_req  = ($urandom_range(0, 99) < if_pct);
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if_flush = if_req && ($urandom_range(0, 9) == 0);
        if (if_flush) if_addr = $urandom & 32'hFFFF_FFFC;
        if (!dm_req || prev_dm_ack) begin
            dm_req   = ($urandom_range(0, 99) < dm_pct);
            dm_we    = 1'($urandom);
            dm_wbits = 2'($urandom);
            dm_rbits = 3'($urandom);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
        end
        mem_rdata = $urandom;
    endtask

    task automatic step_and_check();
        int  k;
        bit  fin, e_if_ack, e_dm_ack, e_we, elig;
        @(negedge clk);
        k        = cyc - m_grant;
        fin      = m_busy && (k == LAT);
        e_dm_ack = fin && m_owner_dm;
        e_if_ack = fin && !m_owner_dm && !m_cancel && !if_flush;
        e_we     = fin && m_owner_dm && m_we;

        check("mem_en",   32'(mem_en),   32'(m_busy));
        check("mem_we",   32'(mem_we),   32'(e_we));
        check("if_ack",   32'(if_ack),   32'(e_if_ack));
        check("dm_ack",   32'(dm_ack),   32'(e_dm_ack));
        check("if_rdata", if_rdata, e_if_ack ? mem_rdata : 32'h0);
        check("dm_rdata", dm_rdata, e_dm_ack ? mem_rdata : 32'h0);
        check("if_stall", 32'(if_stall), 32'(if_req && !e_if_ack));
        check("dm_stall", 32'(dm_stall), 32'(dm_req && !e_dm_ack));
        if (m_busy) check("mem_addr", mem_addr, m_addr);
        if (m_busy && m_owner_dm) begin
            check("mem_wdata", mem_wdata, m_wdata);
            check("mem_wbits", 32'(mem_wbits), 32'(m_wbits));
            check("mem_rbits", 32'(mem_rbits), 32'(m_rbits));
        end
        if (mem_we) obs_stores++;
        if (e_we) m_stores++;

        if (m_busy) begin
            if (!m_owner_dm && if_flush) m_cancel = 1;
            if (fin) begin m_busy = 0; m_cancel = 0; end
        end else begin
            elig = if_req && !if_flush;
            if (dm_req && (m_starve < SMAX || !elig)) begin
                m_busy = 1; m_owner_dm = 1; m_grant = cyc;
                m_addr = dm_addr; m_wdata = dm_wdata; m_we = dm_we;
                m_wbits = dm_wbits; m_rbits = dm_rbits;
                if (elig) m_starve++;
            end else if (elig) begin
                m_busy = 1; m_owner_dm = 0; m_grant = cyc;
                m_addr = if_addr; m_we = 0; m_starve = 0;
            end
        end
        prev_if_ack = e_if_ack;
        prev_dm_ack = e_dm_ack;
        last_e_we   = e_we;
        cyc++;
    endtask

    task automatic run(input int n, input int if_pct, input int dm_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(if_pct, dm_pct);
            step_and_check();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        mem_rdata = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        check("rst_mem_en",   32'(mem_en), 32'h0);
        check("rst_mem_we",   32'(mem_we), 32'h0);
        check("rst_acks",     32'({if_ack, dm_ack}), 32'h0);
        check("rst_rdata",    if_rdata | dm_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_wdata",    mem_wdata, 32'h0);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bit hit;
        m_stores = 0; obs_stores = 0;
        model_reset();
        do_reset();

        run(1500, 60, 40);
        run(800, 90, 100);
        run(400, 100, 20);
        check("store_count", 32'(obs_stores), 32'(m_stores));

        // Store racing a fetch, then an asynchronous reset during the write cycle.
        do_reset();
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(posedge clk); #1;
            if_req = 1; if_flush = 0; if_addr = 32'h0000_3000;
            dm_req = 1; dm_we = 1; dm_wbits = 2'b00; dm_rbits = 3'b000;
            dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
            mem_rdata = $urandom;
            step_and_check();
            hit = last_e_we;
        end
        check("rst_store_reached", 32'(hit), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_we",   32'(mem_we), 32'h0);
        check("arst_mem_en",   32'(mem_en), 32'h0);
        check("arst_dm_ack",   32'(dm_ack), 32'h0);
        check("arst_dm_rdata", dm_rdata, 32'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_wdata",    mem_wdata, 32'h0);
        do_reset();

        run(400, 50, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
